// File: rtl/qq_arb_pkg.sv
// Shared types and helpers for the QuickQ client arbiter.
// Op encodings match the client-side cl_op field.
package qq_arb_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ENQ  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_REPL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int nw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An op is refused when it cannot be applied to the queue as it stands.
  function automatic logic op_rejected(input op_t op, input logic full, input logic empty);
    logic rej;
    case (op)
      OP_ENQ:  rej = full;
      OP_DEQ:  rej = empty;
      OP_REPL: rej = empty;
      default: rej = 1'b1;
    endcase
    return rej;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at N.
// The pointer itself is owned by the caller.
import qq_arb_pkg::*;

module rr_arb #(
  parameter int N  = 4,
  parameter int NW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [NW-1:0] ptr,
  output logic [NW-1:0] idx,
  output logic          valid
);

  int          cand_s;
  logic [NW-1:0] cand_idx_s;
  logic        hit_s;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    idx        = '0;
    valid      = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    hit_s      = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s     = int'(ptr) + k;
      cand_s     = (cand_s >= N) ? (cand_s - N) : cand_s;
      cand_idx_s = NW'(cand_s);
      hit_s      = req[cand_idx_s];
      idx        = hit_s ? cand_idx_s : idx;
      valid      = valid | hit_s;
    end
  end

endmodule

// File: rtl/qq_arbiter.sv
// Serialises N clients onto one QuickQ queue: round-robin grant, op screening,
// one op in flight, head value returned to the client on completion.
import qq_arb_pkg::*;

module qq_arbiter #(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int MIN_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   cl_req,
  input  logic [2*N-1:0] cl_op,
  input  logic [W*N-1:0] cl_data,
  output logic [N-1:0]   cl_done,
  output logic           cl_err,
  output logic [W-1:0]   rsp_data,
  output logic           q_enq,
  output logic           q_deq,
  output logic           q_repl,
  output logic [W-1:0]   q_din,
  input  logic           q_rdy,
  input  logic           q_full,
  input  logic           q_empty,
  input  logic [W-1:0]   q_dout
);

  localparam int NW = nw(N);
  localparam int CW = nw(MIN_LAT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_LAT - 1);
  localparam logic [NW-1:0] LAST_IDX = NW'(N - 1);
  localparam logic [N-1:0]  ONE_N    = N'(1);

  state_t        state_r;
  logic [NW-1:0] ptr_r;
  logic [NW-1:0] win_r;
  op_t           op_r;
  logic [W-1:0]  data_r;
  logic [CW-1:0] cnt_r;

  logic [NW-1:0] win_idx_s;
  logic          win_vld_s;
  logic          illegal_s;
  logic [N-1:0]  done_vec_s;

  rr_arb #(.N(N), .NW(NW)) u_rr_arb (
    .req   (cl_req),
    .ptr   (ptr_r),
    .idx   (win_idx_s),
    .valid (win_vld_s)
  );

  assign illegal_s  = op_rejected(op_r, q_full, q_empty);
  assign done_vec_s = ONE_N << win_r;

  // Request FSM; strobes, completion pulse and error are single-cycle registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ptr_r    <= '0;
      win_r    <= '0;
      op_r     <= OP_NONE;
      data_r   <= '0;
      cnt_r    <= '0;
      cl_done  <= '0;
      cl_err   <= 1'b0;
      rsp_data <= '0;
      q_enq    <= 1'b0;
      q_deq    <= 1'b0;
      q_repl   <= 1'b0;
      q_din    <= '0;
    end else begin
      q_enq   <= 1'b0;
      q_deq   <= 1'b0;
      q_repl  <= 1'b0;
      cl_done <= '0;
      cl_err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_vld_s) begin
            win_r   <= win_idx_s;
            op_r    <= op_t'(cl_op[2*win_idx_s +: 2]);
            data_r  <= cl_data[W*win_idx_s +: W];
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (illegal_s) begin
            rsp_data <= '0;
            cl_done  <= done_vec_s;
            cl_err   <= 1'b1;
            state_r  <= ST_RESP;
          end else if (q_rdy) begin
            case (op_r)
              OP_ENQ:  q_enq  <= 1'b1;
              OP_DEQ:  q_deq  <= 1'b1;
              OP_REPL: q_repl <= 1'b1;
              default: q_enq  <= 1'b0;
            endcase
            q_din    <= data_r;
            rsp_data <= (op_r == OP_ENQ) ? '0 : q_dout;
            cnt_r    <= '0;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Saturate so a long q_rdy stall cannot wrap the counter.
          if (cnt_r < CNT_MAX) begin
            cnt_r <= cnt_r + 1'b1;
          end
          if ((cnt_r >= CNT_MAX) && q_rdy) begin
            cl_done <= done_vec_s;
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          ptr_r   <= (win_r == LAST_IDX) ? '0 : (win_r + 1'b1);
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qq_arbiter.sv
// Directed bench for qq_arbiter: queue side is driven as static flags/head value,
// each scenario task checks its own expected strobes, completions and latencies.
module tb_qq_arbiter;

  localparam logic [1:0] OPC_NONE = 2'b00;
  localparam logic [1:0] OPC_ENQ  = 2'b01;
  localparam logic [1:0] OPC_DEQ  = 2'b10;
  localparam logic [1:0] OPC_REPL = 2'b11;

  logic        clk;
  logic        rst;
  logic [3:0]  cl_req;
  logic [7:0]  cl_op;
  logic [31:0] cl_data;
  logic [3:0]  cl_done;
  logic        cl_err;
  logic [7:0]  rsp_data;
  logic        q_enq, q_deq, q_repl;
  logic [7:0]  q_din;
  logic        q_rdy, q_full, q_empty;
  logic [7:0]  q_dout;
  logic [23:0] outs;

  int errors = 0;
  int checks = 0;

  logic [3:0] obs_done;
  logic       obs_err;
  logic [7:0] obs_rsp;
  logic [7:0] obs_din;
  int obs_lat, obs_enq, obs_deq, obs_repl, obs_pre, obs_multi;

  qq_arbiter #(.W(8), .N(4), .MIN_LAT(2)) dut (
    .clk(clk), .rst(rst), .cl_req(cl_req), .cl_op(cl_op), .cl_data(cl_data),
    .cl_done(cl_done), .cl_err(cl_err), .rsp_data(rsp_data),
    .q_enq(q_enq), .q_deq(q_deq), .q_repl(q_repl), .q_din(q_din),
    .q_rdy(q_rdy), .q_full(q_full), .q_empty(q_empty), .q_dout(q_dout)
  );

  assign outs = {cl_done, cl_err, rsp_data, q_enq, q_deq, q_repl, q_din};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op from client c starting in an IDLE cycle; q_rdy held low for rdy_hold cycles.
  task automatic run_op(input int c, input logic [1:0] op, input logic [7:0] d, input int rdy_hold);
    bit got = 0;
    @(negedge clk);
    cl_op[2*c +: 2]   = op;
    cl_data[8*c +: 8] = d;
    cl_req[c]         = 1'b1;
    if (rdy_hold > 0) q_rdy = 1'b0;
    obs_done = '0; obs_err = 1'b0; obs_rsp = '0; obs_din = '0;
    obs_lat = 0; obs_enq = 0; obs_deq = 0; obs_repl = 0; obs_pre = 0; obs_multi = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      obs_enq  += int'(q_enq);
      obs_deq  += int'(q_deq);
      obs_repl += int'(q_repl);
      if (int'(q_enq) + int'(q_deq) + int'(q_repl) > 1) obs_multi++;
      if (q_enq | q_deq | q_repl) begin
        obs_din = q_din;
        if (i <= rdy_hold) obs_pre++;
      end
      if (i == rdy_hold) q_rdy = 1'b1;
      if (cl_done != 4'b0000) begin
        obs_done  = cl_done;
        obs_err   = cl_err;
        obs_rsp   = rsp_data;
        obs_lat   = i;
        cl_req[c] = 1'b0;
        got       = 1;
      end
    end
    q_rdy = 1'b1;
    checks++;
    if (!got) begin
      errors++;
      cl_req[c] = 1'b0;
      $display("FAIL op_timeout client=%0d got no cl_done within 60 cycles, required one", c);
    end
  endtask

  task automatic test_reset();
    logic [3:0] order [4];
    logic [3:0] exp_v;
    int n = 0;
    for (int k = 0; k < 4; k++) order[k] = 4'b0000;
    rst = 1'b1; cl_req = 4'b1111;
    cl_op = {OPC_ENQ, OPC_ENQ, OPC_ENQ, OPC_ENQ}; cl_data = 32'h44332211;
    q_full = 1'b0; q_empty = 1'b1; q_rdy = 1'b1; q_dout = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 24'h000000) begin
      errors++; $display("FAIL reset_outputs got %h required 000000", outs);
    end
    rst = 1'b0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (cl_done != 4'b0000) begin
        order[n] = cl_done;
        cl_req   = cl_req & ~cl_done;
        n++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      exp_v = 4'b0001 << k;
      checks++;
      if (order[k] !== exp_v) begin
        errors++; $display("FAIL reset_grant_order[%0d] got %b required %b", k, order[k], exp_v);
      end
    end
    cl_req = 4'b0000;
  endtask

  task automatic test_enq();
    q_full = 1'b0; q_empty = 1'b1;
    run_op(2, OPC_ENQ, 8'h35, 0);
    checks++;
    if ({obs_enq, obs_deq, obs_repl} !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL enq_strobes got enq=%0d deq=%0d repl=%0d required 1/0/0", obs_enq, obs_deq, obs_repl);
    end
    checks++;
    if (obs_din !== 8'h35) begin errors++; $display("FAIL enq_din got %h required 35", obs_din); end
    checks++;
    if ({obs_done, obs_err, obs_rsp} !== {4'b0100, 1'b0, 8'h00}) begin
      errors++; $display("FAIL enq_resp got done=%b err=%b rsp=%h required 0100/0/00", obs_done, obs_err, obs_rsp);
    end
    checks++;
    if (obs_lat !== 4) begin errors++; $display("FAIL enq_latency got %0d required 4", obs_lat); end
  endtask

  task automatic test_deq_repl();
    q_full = 1'b0; q_empty = 1'b0; q_dout = 8'h07;
    run_op(1, OPC_DEQ, 8'hEE, 0);
    checks++;
    if ({obs_enq, obs_deq, obs_repl} !== {32'd0, 32'd1, 32'd0}) begin
      errors++; $display("FAIL deq_strobes got enq=%0d deq=%0d repl=%0d required 0/1/0", obs_enq, obs_deq, obs_repl);
    end
    checks++;
    if ({obs_done, obs_err, obs_rsp} !== {4'b0010, 1'b0, 8'h07}) begin
      errors++; $display("FAIL deq_resp got done=%b err=%b rsp=%h required 0010/0/07", obs_done, obs_err, obs_rsp);
    end
    q_dout = 8'h5A;
    run_op(0, OPC_REPL, 8'h11, 0);
    checks++;
    if ({obs_repl, obs_din} !== {32'd1, 8'h11}) begin
      errors++; $display("FAIL repl_strobe got repl=%0d din=%h required 1/11", obs_repl, obs_din);
    end
    checks++;
    if ({obs_done, obs_err, obs_rsp} !== {4'b0001, 1'b0, 8'h5A}) begin
      errors++; $display("FAIL repl_resp got done=%b err=%b rsp=%h required 0001/0/5a", obs_done, obs_err, obs_rsp);
    end
  endtask

  task automatic test_rejects();
    q_full = 1'b1; q_empty = 1'b0;
    run_op(3, OPC_ENQ, 8'h99, 0);
    checks++;
    if ({obs_enq, obs_deq, obs_repl} !== {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL full_no_strobe got enq=%0d deq=%0d repl=%0d required 0/0/0", obs_enq, obs_deq, obs_repl);
    end
    checks++;
    if ({obs_done, obs_err, obs_rsp, obs_lat} !== {4'b1000, 1'b1, 8'h00, 32'd2}) begin
      errors++; $display("FAIL full_resp got done=%b err=%b rsp=%h lat=%0d required 1000/1/00/2", obs_done, obs_err, obs_rsp, obs_lat);
    end
    q_full = 1'b0; q_empty = 1'b1;
    run_op(0, OPC_DEQ, 8'h00, 0);
    checks++;
    if ({obs_done, obs_err, obs_lat, obs_deq} !== {4'b0001, 1'b1, 32'd2, 32'd0}) begin
      errors++; $display("FAIL empty_deq got done=%b err=%b lat=%0d deq=%0d required 0001/1/2/0", obs_done, obs_err, obs_lat, obs_deq);
    end
    q_empty = 1'b0;
    run_op(1, OPC_NONE, 8'h42, 0);
    checks++;
    if ({obs_done, obs_err, obs_enq + obs_deq + obs_repl} !== {4'b0010, 1'b1, 32'd0}) begin
      errors++; $display("FAIL op00_reject got done=%b err=%b strobes=%0d required 0010/1/0", obs_done, obs_err, obs_enq + obs_deq + obs_repl);
    end
  endtask

  task automatic test_rdy_stall();
    q_full = 1'b0; q_empty = 1'b0;
    run_op(2, OPC_ENQ, 8'hC3, 5);
    checks++;
    if (obs_pre !== 0) begin errors++; $display("FAIL stall_early_strobe got %0d required 0", obs_pre); end
    checks++;
    if ({obs_enq, obs_din, obs_done, obs_lat} !== {32'd1, 8'hC3, 4'b0100, 32'd8}) begin
      errors++; $display("FAIL stall_result got enq=%0d din=%h done=%b lat=%0d required 1/c3/0100/8", obs_enq, obs_din, obs_done, obs_lat);
    end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    q_empty = 1'b0; q_dout = 8'h66;
    @(negedge clk);
    cl_op[2 +: 2] = OPC_DEQ; cl_req[1] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (q_deq !== 1'b1) begin errors++; $display("FAIL midreset_precondition q_deq got %b required 1", q_deq); end
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 24'h000000) begin
      errors++; $display("FAIL midreset_outputs got %h required 000000", outs);
    end
    cl_req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (cl_done != 4'b0000 || q_enq || q_deq || q_repl) late++;
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles required 0", late); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] grants [10];
    logic [3:0] exp_v;
    int n = 0, multi = 0, strobes = 0;
    for (int k = 0; k < 10; k++) grants[k] = 4'b0000;
    q_full = 1'b0; q_empty = 1'b0;
    @(negedge clk);
    cl_op = {OPC_NONE, OPC_NONE, OPC_ENQ, OPC_ENQ}; cl_data = 32'h0000B2A1;
    cl_req = 4'b0011;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      strobes += int'(q_enq) + int'(q_deq) + int'(q_repl);
      if (int'(q_enq) + int'(q_deq) + int'(q_repl) > 1) multi++;
      if (cl_done != 4'b0000) begin grants[n] = cl_done; n++; end
    end
    cl_req = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      exp_v = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      checks++;
      if (grants[k] !== exp_v) begin
        errors++; $display("FAIL b2b_grant[%0d] got %b required %b", k, grants[k], exp_v);
      end
    end
    checks++;
    if ({multi, strobes} !== {32'd0, 32'd10}) begin
      errors++; $display("FAIL b2b_strobes got multi=%0d total=%0d required 0/10", multi, strobes);
    end
  endtask

  initial begin
    cl_req = 4'b0000; cl_op = 8'h00; cl_data = 32'h0; rst = 1'b1;
    q_rdy = 1'b1; q_full = 1'b0; q_empty = 1'b1; q_dout = 8'h00;
    test_reset();
    test_enq();
    test_deq_repl();
    test_rejects();
    test_rdy_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
